// File: rtl/screen_writer.sv
// CPU-side write port into the 512x256 mono VRAM: PIXEL read-modify-write, WORD write, CLEAR sweep.
// Optional full-screen CLEAR sweep is built only when SCREEN_WRITER_CLEAR_EN is defined.
module screen_writer #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
`ifdef SCREEN_WRITER_CLEAR_EN
  ,
  parameter int CLR_LAST = 8191
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic              cmd_color,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
`ifdef SCREEN_WRITER_CLEAR_EN
    ,
    S_CLR  = 2'd3
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;
  logic [3:0]        bit_q, bit_d;
  logic              color_q, color_d;
  logic              pix_q, pix_d;

  function automatic logic [DATA_W-1:0] merge_pixel(input logic [DATA_W-1:0] word,
                                                    input logic [3:0] idx,
                                                    input logic value);
    logic [DATA_W-1:0] r;
    r      = word;
    r[idx] = value;
    return r;
  endfunction

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    bit_d   = bit_q;
    color_d = color_q;
    pix_d   = pix_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00: begin
              state_d = S_RD;
              addr_d  = {cmd_y, cmd_x[8:4]};
              bit_d   = cmd_x[3:0];
              color_d = cmd_color;
              pix_d   = 1'b1;
            end
            2'b01: begin
              state_d = S_WR;
              addr_d  = {cmd_y, cmd_x[8:4]};
              we_d    = 1'b1;
              wdata_d = cmd_data;
              pix_d   = 1'b0;
            end
`ifdef SCREEN_WRITER_CLEAR_EN
            2'b10: begin
              state_d = S_CLR;
              addr_d  = {ADDR_W{1'b0}};
              we_d    = 1'b1;
              wdata_d = cmd_data;
              pix_d   = 1'b0;
            end
`endif
            default: begin
              done_d = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        state_d = S_WR;
        we_d    = 1'b1;
      end
      S_WR: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
`ifdef SCREEN_WRITER_CLEAR_EN
      // Sweep stops on the last address rather than wrapping the counter back to 0.
      S_CLR: begin
        if (addr_q == ADDR_W'(CLR_LAST)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          we_d   = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      we_q    <= 1'b0;
      wdata_q <= {DATA_W{1'b0}};
      done_q  <= 1'b0;
      bit_q   <= 4'd0;
      color_q <= 1'b0;
      pix_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      bit_q   <= bit_d;
      color_q <= color_d;
      pix_q   <= pix_d;
    end
  end

  // Read data arrives in the WR cycle itself, so the pixel merge must be combinational.
  assign vram_wdata = (state_q == S_WR && pix_q) ? merge_pixel(vram_rdata, bit_q, color_q) : wdata_q;
  assign vram_addr  = addr_q;
  assign vram_we    = we_q;
  assign done       = done_q;
  assign cmd_ready  = (state_q == S_IDLE) && !rst;

endmodule

// File: tb/tb_screen_writer.sv
// Self-checking bench for screen_writer: VRAM environment plus a word-level reference image.
module tb_screen_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [8:0]  cmd_x;
  logic [7:0]  cmd_y;
  logic        cmd_color;
  logic [15:0] cmd_data;
  logic [12:0] vram_addr;
  logic [15:0] vram_rdata;
  logic        vram_we;
  logic [15:0] vram_wdata;
  logic        done;

  logic        pre_we;
  logic [12:0] pre_addr;
  logic [15:0] pre_data;

  logic [15:0] mem     [0:8191];
  logic [15:0] ref_mem [0:8191];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  screen_writer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
    .cmd_data(cmd_data), .vram_addr(vram_addr), .vram_rdata(vram_rdata),
    .vram_we(vram_we), .vram_wdata(vram_wdata), .done(done)
  );

  // VRAM: one write port, one synchronous read port, plus a preload port for the bench.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int x, input int y, input logic c, input logic [15:0] d);
    logic [31:0] xv, yv;
    xv = x; yv = y;
    cmd_op = op; cmd_x = xv[8:0]; cmd_y = yv[7:0]; cmd_color = c; cmd_data = d;
    cmd_valid = 1'b1;
    chk("ready_before_accept", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_pixel(input int x, input int y, input logic c);
    int a;
    logic [15:0] w;
    a = y * 32 + x / 16;
    w = ref_mem[a];
    w[x % 16] = c;
    issue(2'b00, x, y, c, 16'h0000);
    chk("pix_rd_addr", {19'd0, vram_addr}, a);
    chk("pix_rd_we", {31'd0, vram_we}, 32'd0);
    chk("pix_busy1", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("pix_wr_we", {31'd0, vram_we}, 32'd1);
    chk("pix_wr_addr", {19'd0, vram_addr}, a);
    chk("pix_wr_data", {16'd0, vram_wdata}, {16'd0, w});
    chk("pix_busy2", {31'd0, cmd_ready}, 32'd0);
    chk("pix_no_early_done", {31'd0, done}, 32'd0);
    ref_mem[a] = w;
    tick();
    chk("pix_done", {31'd0, done}, 32'd1);
    chk("pix_we_off", {31'd0, vram_we}, 32'd0);
    chk("pix_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic do_word(input int x, input int y, input logic [15:0] d);
    int a;
    a = y * 32 + x / 16;
    issue(2'b01, x, y, 1'b0, d);
    chk("word_we", {31'd0, vram_we}, 32'd1);
    chk("word_addr", {19'd0, vram_addr}, a);
    chk("word_data", {16'd0, vram_wdata}, {16'd0, d});
    chk("word_busy", {31'd0, cmd_ready}, 32'd0);
    ref_mem[a] = d;
    tick();
    chk("word_done", {31'd0, done}, 32'd1);
    chk("word_we_off", {31'd0, vram_we}, 32'd0);
    chk("word_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic do_noop(input logic [1:0] op);
    issue(op, $urandom_range(0, 511), $urandom_range(0, 255), 1'b1, 16'hBEEF);
    chk("noop_done", {31'd0, done}, 32'd1);
    chk("noop_we", {31'd0, vram_we}, 32'd0);
    chk("noop_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("noop_done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int bad;
    logic [15:0] v;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_x = 9'd0; cmd_y = 8'd0;
    cmd_color = 1'b0; cmd_data = 16'h0000;
    pre_we = 1'b1; pre_addr = 13'd0; pre_data = 16'h0000;

    // Preload VRAM under reset; addr 162 and 8191 get the directed contents.
    for (int i = 0; i < 8192; i++) begin
      v = $urandom();
      if (i == 162) v = 16'h0000;
      if (i == 8191) v = 16'hFFFF;
      pre_addr = i[12:0]; pre_data = v; ref_mem[i] = v;
      tick();
    end
    pre_we = 1'b0;
    tick();
    chk("rst_we", {31'd0, vram_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_addr", {19'd0, vram_addr}, 32'd0);
    chk("rst_wdata", {16'd0, vram_wdata}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_release_ready", {31'd0, cmd_ready}, 32'd1);

    do_pixel(37, 5, 1'b1);
    chk("pix37_mem", {16'd0, mem[162]}, 32'h0020);
    do_pixel(511, 255, 1'b0);
    chk("pix511_mem", {16'd0, mem[8191]}, 32'h7FFF);
    for (int i = 0; i < 24; i++)
      do_pixel($urandom_range(0, 511), $urandom_range(0, 255), 1'($urandom_range(0, 1)));

    do_word(16, 1, 16'hA5A5);
    chk("word33_mem", {16'd0, mem[33]}, 32'hA5A5);
    for (int i = 0; i < 12; i++)
      do_word($urandom_range(0, 511), $urandom_range(0, 255), 16'($urandom()));

    do_noop(2'b11);

`ifdef SCREEN_WRITER_CLEAR_EN
    v = 16'($urandom());
    issue(2'b10, 0, 0, 1'b0, v);
    bad = 0;
    for (int k = 0; k < 8192; k++) begin
      if (!(vram_we === 1'b1 && vram_addr === 13'(k) && vram_wdata === v &&
            done === 1'b0 && cmd_ready === 1'b0)) bad++;
      tick();
    end
    chk("clr_sweep_bad_cycles", bad, 32'd0);
    chk("clr_done", {31'd0, done}, 32'd1);
    chk("clr_we_off", {31'd0, vram_we}, 32'd0);
    chk("clr_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 8192; i++) ref_mem[i] = v;

    issue(2'b10, 0, 0, 1'b0, 16'h1234);
    for (int k = 0; k < 300; k++) begin
      if (vram_addr == 13'd100) break;
      tick();
    end
    chk("clr_reach_100", {19'd0, vram_addr}, 32'd100);
    for (int i = 0; i <= 100; i++) ref_mem[i] = 16'h1234;
    rst = 1'b1;
    tick();
    chk("clr_rst_we", {31'd0, vram_we}, 32'd0);
    chk("clr_rst_done", {31'd0, done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("clr_rst_no_done", {31'd0, done}, 32'd0);
    chk("clr_rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("clr_rst_we_idle", {31'd0, vram_we}, 32'd0);
`else
    do_noop(2'b10);
`endif

    // Reset during a PIXEL read cycle: no write, no done.
    issue(2'b00, 200, 100, 1'b1, 16'h0000);
    rst = 1'b1;
    tick();
    chk("pixrst_we", {31'd0, vram_we}, 32'd0);
    chk("pixrst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("pixrst_no_done", {31'd0, done}, 32'd0);
    chk("pixrst_ready", {31'd0, cmd_ready}, 32'd1);

    for (int i = 0; i < 12; i++)
      do_pixel($urandom_range(0, 511), $urandom_range(0, 255), 1'($urandom_range(0, 1)));

    bad = 0;
    for (int i = 0; i < 8192; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("vram_image_bad_words", bad, 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
